// File: rtl/mbist_sched.sv
// rtl/mbist_sched.sv - memory-BIST scheduler: register bank plus sequencer over per-memory BIST engines
module mbist_sched #(
    parameter int NUM_MEM        = 9,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               test_enable,
    input  logic               cpu_wr,
    input  logic [4:0]         cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    input  logic [NUM_MEM-1:0] mbist_done,
    input  logic [NUM_MEM-1:0] mbist_fail,
    output logic               mbist_rst,
    output logic [NUM_MEM-1:0] mbist_start,
    output logic               busy,
    output logic               irq
);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_GAP, S_FIN} state_t;

    localparam logic [15:0] VALID   = 16'((32'd1 << NUM_MEM) - 32'd1);
    localparam logic [15:0] RST_END = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TMO_END = 16'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic [15:0]        r_mask, r_work, r_fail, r_tmo, r_cnt;
    logic [3:0]         r_idx;
    logic               r_done, r_any_fail, r_any_tmo, r_aborted;
    logic               r_busy, r_irq, r_rst;
    logic [NUM_MEM-1:0] r_start;
    logic [7:0]         r_rdata;

    logic [15:0] w_done16, w_fail16;
    logic        w_ctrl_wr, w_go, w_abort, w_first_found, w_next_found;
    logic [3:0]  w_first_idx, w_next_idx;

    assign w_done16  = 16'(mbist_done);
    assign w_fail16  = 16'(mbist_fail);
    assign w_ctrl_wr = cpu_wr && (cpu_addr == 5'h00);
    // Abort in the same write as go wins, so go requires the abort bit clear.
    assign w_go      = w_ctrl_wr && cpu_wdata[0] && !cpu_wdata[1] && test_enable;
    assign w_abort   = (w_ctrl_wr && cpu_wdata[1]) || !test_enable;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = 4'd0;
        w_next_found  = 1'b0;
        w_next_idx    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = 4'(i);
            end
            if (r_work[i] && (i > int'(r_idx))) begin
                w_next_found = 1'b1;
                w_next_idx   = 4'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_work     <= '0;
            r_fail     <= '0;
            r_tmo      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_any_fail <= 1'b0;
            r_any_tmo  <= 1'b0;
            r_aborted  <= 1'b0;
            r_busy     <= 1'b0;
            r_irq      <= 1'b0;
            r_rst      <= 1'b0;
            r_start    <= '0;
        end else begin
            if (cpu_wr && cpu_addr == 5'h01) r_mask[7:0]  <= cpu_wdata & VALID[7:0];
            if (cpu_wr && cpu_addr == 5'h02) r_mask[15:8] <= cpu_wdata & VALID[15:8];
            if (cpu_wr && cpu_addr == 5'h03) begin
                r_done     <= 1'b0;
                r_any_fail <= 1'b0;
                r_any_tmo  <= 1'b0;
                r_aborted  <= 1'b0;
                r_irq      <= 1'b0;
            end
            // Sequence-end updates below come later in the block, so they beat a STATUS write.
            if ((r_state == S_RST || r_state == S_RUN || r_state == S_GAP) && w_abort) begin
                r_state    <= S_FIN;
                r_rst      <= 1'b0;
                r_start    <= '0;
                r_busy     <= 1'b0;
                r_irq      <= 1'b1;
                r_done     <= 1'b1;
                r_aborted  <= 1'b1;
                r_any_fail <= |r_fail;
                r_any_tmo  <= |r_tmo;
                r_idx      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_go) begin
                        r_work     <= r_mask;
                        r_fail     <= '0;
                        r_tmo      <= '0;
                        r_aborted  <= 1'b0;
                        r_any_fail <= 1'b0;
                        r_any_tmo  <= 1'b0;
                        if (w_first_found) begin
                            r_state <= S_RST;
                            r_idx   <= w_first_idx;
                            r_rst   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_irq   <= 1'b1;
                        end
                    end
                    S_RST: begin
                        if (r_cnt == RST_END) begin
                            r_state <= S_RUN;
                            r_rst   <= 1'b0;
                            r_start <= NUM_MEM'(1) << r_idx;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_RUN: begin
                        if (w_done16[r_idx]) begin
                            r_fail[r_idx] <= w_fail16[r_idx];
                            r_start       <= '0;
                            r_state       <= S_GAP;
                        end else if (r_cnt == TMO_END) begin
                            r_fail[r_idx] <= 1'b1;
                            r_tmo[r_idx]  <= 1'b1;
                            r_start       <= '0;
                            r_state       <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_GAP: begin
                        if (w_next_found) begin
                            r_state <= S_RST;
                            r_idx   <= w_next_idx;
                            r_rst   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state    <= S_FIN;
                            r_busy     <= 1'b0;
                            r_irq      <= 1'b1;
                            r_done     <= 1'b1;
                            r_any_fail <= |r_fail;
                            r_any_tmo  <= |r_tmo;
                            r_idx      <= '0;
                        end
                    end
                    S_FIN:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= 8'h00;
        end else begin
            case (cpu_addr)
                5'h01:   r_rdata <= r_mask[7:0];
                5'h02:   r_rdata <= r_mask[15:8];
                5'h03:   r_rdata <= {3'b000, r_aborted, r_any_tmo, r_any_fail, r_done, r_busy};
                5'h04:   r_rdata <= r_fail[7:0];
                5'h05:   r_rdata <= r_fail[15:8];
                5'h06:   r_rdata <= r_tmo[7:0];
                5'h07:   r_rdata <= r_tmo[15:8];
                5'h08:   r_rdata <= {4'h0, r_idx};
                default: r_rdata <= 8'h00;
            endcase
        end
    end

    assign cpu_rdata   = r_rdata;
    assign mbist_rst   = r_rst;
    assign mbist_start = r_start;
    assign busy        = r_busy;
    assign irq         = r_irq;

endmodule

// File: tb/tb_mbist_sched.sv
// tb/tb_mbist_sched.sv - directed self-checking bench for mbist_sched
module tb_mbist_sched;
    localparam int NM = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          test_enable = 1'b1;
    logic          cpu_wr = 1'b0;
    logic [4:0]    cpu_addr = 5'h1f;
    logic [7:0]    cpu_wdata = 8'h00;
    logic [7:0]    cpu_rdata;
    logic [NM-1:0] mbist_done = '0;
    logic [NM-1:0] mbist_fail = '0;
    logic          mbist_rst;
    logic [NM-1:0] mbist_start;
    logic          busy;
    logic          irq;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int rst_cnt = 0, onehot_err = 0, order_n = 0;
    int start_cnt[NM];
    int order[8];
    logic [NM-1:0] prev_start = '0;
    logic [7:0] rd;

    mbist_sched #(.NUM_MEM(NM), .RST_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .test_enable(test_enable),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .mbist_done(mbist_done), .mbist_fail(mbist_fail), .mbist_rst(mbist_rst),
        .mbist_start(mbist_start), .busy(busy), .irq(irq)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mbist_rst) rst_cnt++;
        for (int i = 0; i < NM; i++) begin
            if (mbist_start[i]) start_cnt[i]++;
            if (mbist_start[i] && !prev_start[i] && order_n < 8) begin
                order[order_n] = i;
                order_n++;
            end
        end
        if ($countones(mbist_start) > 1) onehot_err++;
        prev_start = mbist_start;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_wr = 1'b0; cpu_addr = 5'h1f;
    endtask

    task automatic rdreg(input logic [4:0] a, output logic [7:0] d);
        cpu_addr = a;
        tick();
        d = cpu_rdata;
        cpu_addr = 5'h1f;
    endtask

    task automatic clr_mon();
        rst_cnt = 0; order_n = 0;
        for (int i = 0; i < NM; i++) start_cnt[i] = 0;
    endtask

    task automatic wait_start(input int idx);
        int k = 0;
        while (mbist_start[idx] !== 1'b1 && k < 100) begin tick(); k++; end
        chk($sformatf("start%0d_seen", idx), 16'(k < 100), 16'd1);
    endtask

    // Holds done[idx] so start[idx] stays high for exactly ncyc cycles.
    task automatic run_engine(input int idx, input int ncyc, input logic f);
        wait_start(idx);
        for (int c = 1; c < ncyc; c++) tick();
        mbist_done[idx] = 1'b1; mbist_fail[idx] = f;
        tick();
        mbist_done[idx] = 1'b0; mbist_fail[idx] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NM; i++) start_cnt[i] = 0;
        tick(); tick();
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_irq", 16'(irq), 16'd0);
        chk("rst_start", 16'(mbist_start), 16'd0);
        chk("rst_mbist_rst", 16'(mbist_rst), 16'd0);
        chk("rst_rdata", 16'(cpu_rdata), 16'd0);
        reset = 1'b1;
        tick();
        rdreg(5'h03, rd); chk("rst_status", 16'(rd), 16'h00);

        // mask bits above NUM_MEM are read-only zero
        wr(5'h02, 8'hff);
        rdreg(5'h02, rd); chk("mask_hi_ro", 16'(rd), 16'h01);
        wr(5'h02, 8'h00);

        // single engine pass
        wr(5'h01, 8'h01);
        clr_mon();
        wr(5'h00, 8'h01);
        chk("t1_busy", 16'(busy), 16'd1);
        chk("t1_rst", 16'(mbist_rst), 16'd1);
        run_engine(0, 10, 1'b0);
        chk("t1_gap_start", 16'(mbist_start), 16'd0);
        tick();
        chk("t1_busy_fin", 16'(busy), 16'd0);
        chk("t1_irq", 16'(irq), 16'd1);
        chk("t1_rst_cycles", 16'(rst_cnt), 16'd4);
        chk("t1_start_cycles", 16'(start_cnt[0]), 16'd10);
        rdreg(5'h03, rd); chk("t1_status", 16'(rd), 16'h02);
        rdreg(5'h04, rd); chk("t1_fail_lo", 16'(rd), 16'h00);

        // three engines, engine 2 fails
        wr(5'h03, 8'h00);
        chk("t2_irq_clr", 16'(irq), 16'd0);
        wr(5'h01, 8'h05);
        wr(5'h02, 8'h01);
        clr_mon();
        wr(5'h00, 8'h01);
        run_engine(0, 3, 1'b0);
        run_engine(2, 5, 1'b1);
        run_engine(8, 2, 1'b0);
        tick();
        chk("t2_irq", 16'(irq), 16'd1);
        chk("t2_order_n", 16'(order_n), 16'd3);
        chk("t2_order0", 16'(order[0]), 16'd0);
        chk("t2_order1", 16'(order[1]), 16'd2);
        chk("t2_order2", 16'(order[2]), 16'd8);
        chk("t2_rst_cycles", 16'(rst_cnt), 16'd12);
        rdreg(5'h04, rd); chk("t2_fail_lo", 16'(rd), 16'h04);
        rdreg(5'h05, rd); chk("t2_fail_hi", 16'(rd), 16'h00);
        rdreg(5'h03, rd); chk("t2_status", 16'(rd), 16'h06);
        wr(5'h03, 8'h5a);
        chk("t2_irq_drop", 16'(irq), 16'd0);
        rdreg(5'h03, rd); chk("t2_status_clr", 16'(rd), 16'h00);

        // timeout on engine 1
        wr(5'h01, 8'h02);
        wr(5'h02, 8'h00);
        clr_mon();
        wr(5'h00, 8'h01);
        wait_start(1);
        rdreg(5'h08, rd); chk("t3_cur", 16'(rd), 16'h01);
        begin
            int k = 0;
            while (mbist_start[1] === 1'b1 && k < 40) begin tick(); k++; end
            chk("t3_start_fell", 16'(k < 40), 16'd1);
        end
        tick();
        chk("t3_start_cycles", 16'(start_cnt[1]), 16'd16);
        rdreg(5'h06, rd); chk("t3_tmo_lo", 16'(rd), 16'h02);
        rdreg(5'h04, rd); chk("t3_fail_lo", 16'(rd), 16'h02);
        rdreg(5'h03, rd); chk("t3_status", 16'(rd), 16'h0e);
        wr(5'h03, 8'h00);

        // abort mid-run
        wr(5'h01, 8'h03);
        clr_mon();
        wr(5'h00, 8'h01);
        wait_start(0);
        wr(5'h00, 8'h02);
        chk("t4_start_off", 16'(mbist_start), 16'd0);
        chk("t4_rst_off", 16'(mbist_rst), 16'd0);
        chk("t4_irq", 16'(irq), 16'd1);
        rdreg(5'h03, rd); chk("t4_status", 16'(rd), 16'h12);
        rdreg(5'h04, rd); chk("t4_fail_lo", 16'(rd), 16'h00);
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("t4_eng1_idle", 16'(start_cnt[1]), 16'd0);
        wr(5'h03, 8'h00);

        // go and abort together: abort wins, go ignored
        wr(5'h00, 8'h03);
        chk("t4b_busy", 16'(busy), 16'd0);
        chk("t4b_rst", 16'(mbist_rst), 16'd0);

        // zero mask
        wr(5'h01, 8'h00);
        clr_mon();
        wr(5'h00, 8'h01);
        chk("t5_irq", 16'(irq), 16'd1);
        rdreg(5'h03, rd); chk("t5_status", 16'(rd), 16'h02);
        chk("t5_no_rst", 16'(rst_cnt), 16'd0);
        wr(5'h03, 8'h00);

        // go with test_enable low is ignored
        wr(5'h01, 8'h01);
        test_enable = 1'b0;
        wr(5'h00, 8'h01);
        chk("t5b_busy", 16'(busy), 16'd0);
        tick(); tick();
        rdreg(5'h03, rd); chk("t5b_status", 16'(rd), 16'h00);
        chk("t5b_no_rst", 16'(rst_cnt), 16'd0);

        // dropping test_enable mid-run aborts
        test_enable = 1'b1;
        wr(5'h00, 8'h01);
        wait_start(0);
        test_enable = 1'b0;
        tick();
        chk("t5c_start_off", 16'(mbist_start), 16'd0);
        rdreg(5'h03, rd); chk("t5c_status", 16'(rd), 16'h12);
        test_enable = 1'b1;
        wr(5'h03, 8'h00);

        // asynchronous reset while engine 3 runs
        wr(5'h01, 8'h08);
        wr(5'h00, 8'h01);
        wait_start(3);
        #2 reset = 1'b0;
        #1;
        chk("t6_start_async", 16'(mbist_start), 16'd0);
        chk("t6_busy_async", 16'(busy), 16'd0);
        #3 reset = 1'b1;
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("t6_start_after", 16'(mbist_start), 16'd0);
        chk("t6_rst_after", 16'(mbist_rst), 16'd0);
        chk("t6_busy_after", 16'(busy), 16'd0);
        rdreg(5'h01, rd); chk("t6_mask_lo", 16'(rd), 16'h00);
        rdreg(5'h03, rd); chk("t6_status", 16'(rd), 16'h00);
        rdreg(5'h08, rd); chk("t6_cur", 16'(rd), 16'h00);

        chk("onehot", 16'(onehot_err), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
